// File: rtl/alu_pwr_ctrl.sv
// alu_pwr_ctrl
// Power-sequencing controller for the gated ALU domain. It drives the power
// switch enable, output isolation and domain reset of the ALU, so the
// domain is always isolated while unpowered or held in reset.
//
// Power-down order: drain in-flight work, isolate, cut power.
// Power-up order:   power, hold reset, release isolation.
// Each power-switch step waits on the pwr_ack handshake.
//
// Optional feature (macro PWR_TIMEOUT_EN):
//   defined   - bounds the pwr_ack waits to TIMEOUT_CYC cycles. On expiry the
//               sticky err flag is set, the domain is forced OFF, and wake
//               requests are ignored until rst_n.
//   undefined - the pwr_ack waits are unbounded and err stays 0.
//
// Parameters:
//   ISO_HOLD_CYC - cycles iso_en is held before power cut and after reset release (>=1)
//   RST_HOLD_CYC - cycles alu_rst_n is held low after pwr_ack rises (>=1)
//   TIMEOUT_CYC  - max cycles waiting on pwr_ack (PWR_TIMEOUT_EN only)
//   CNT_W        - hold/timeout counter width
//
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   sleep_req  in  level request to power the domain down
//   wake_req   in  level request to power the domain up
//   alu_busy   in  ALU operation in flight
//   pwr_ack    in  power-switch status (1 = rail good), synchronous to clk
//   alu_pwr_en out power switch enable
//   iso_en     out isolation enable (1 = ALU outputs clamped)
//   alu_rst_n  out ALU domain reset, active low
//   domain_on  out high only in ACTIVE
//   pd_state   out current state encoding
//   err        out sticky power-switch timeout flag

module alu_pwr_ctrl #(
    parameter int unsigned ISO_HOLD_CYC = 2,
    parameter int unsigned RST_HOLD_CYC = 4,
    parameter int unsigned TIMEOUT_CYC  = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       alu_busy,
    input  logic       pwr_ack,
    output logic       alu_pwr_en,
    output logic       iso_en,
    output logic       alu_rst_n,
    output logic       domain_on,
    output logic [2:0] pd_state,
    output logic       err
);

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        PWR_ON   = 3'd1,
        RST_HOLD = 3'd2,
        ISO_REL  = 3'd3,
        ACTIVE   = 3'd4,
        DRAIN    = 3'd5,
        ISO_SET  = 3'd6,
        PWR_OFF  = 3'd7
    } state_t;

    // Terminal counts: a state lasting N cycles leaves when the counter,
    // cleared on entry, reaches N-1.
    localparam logic [CNT_W-1:0] RstLast = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] IsoLast = CNT_W'(ISO_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;
`ifdef PWR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYC - 1);
`endif

    // Reject parameter sets the counter cannot represent.
    if (ISO_HOLD_CYC < 1 || RST_HOLD_CYC < 1 || TIMEOUT_CYC < 1 ||
        ISO_HOLD_CYC > 2**CNT_W - 1 || RST_HOLD_CYC > 2**CNT_W - 1 ||
        TIMEOUT_CYC > 2**CNT_W - 1) begin : g_bad_params
        $error("alu_pwr_ctrl: hold/timeout parameters out of range for CNT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             pwr_en_d, iso_d, rst_n_d, on_d;

    // Next-state logic. Requests are only looked at in OFF and ACTIVE, so a
    // started sequence always runs to completion.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            OFF: begin
                if (wake_req && !err_q) state_d = PWR_ON;
            end
            PWR_ON: begin
                if (pwr_ack) begin
                    state_d = RST_HOLD;
                end
`ifdef PWR_TIMEOUT_EN
                else if (cnt_q == TmoLast) begin
                    state_d = OFF;
                    err_d   = 1'b1;
                end
`endif
            end
            RST_HOLD: begin
                if (cnt_q == RstLast) state_d = ISO_REL;
            end
            ISO_REL: begin
                if (cnt_q == IsoLast) state_d = ACTIVE;
            end
            ACTIVE: begin
                // Sleep has priority; wake is meaningless while already on.
                if (sleep_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!alu_busy) state_d = ISO_SET;
            end
            ISO_SET: begin
                if (cnt_q == IsoLast) state_d = PWR_OFF;
            end
            PWR_OFF: begin
                if (!pwr_ack) begin
                    state_d = OFF;
                end
`ifdef PWR_TIMEOUT_EN
                else if (cnt_q == TmoLast) begin
                    state_d = OFF;
                    err_d   = 1'b1;
                end
`endif
            end
            default: state_d = OFF;
        endcase
    end

    // Counter restarts on every state change and otherwise saturates so
    // a long wait can never wrap back into a terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output decode from the state being entered, so the registered outputs
    // change on the same edge as the state register.
    always_comb begin
        pwr_en_d = 1'b0;
        iso_d    = 1'b1;
        rst_n_d  = 1'b0;
        on_d     = 1'b0;
        unique case (state_d)
            OFF:      begin pwr_en_d = 1'b0; iso_d = 1'b1; rst_n_d = 1'b0; end
            PWR_ON:   begin pwr_en_d = 1'b1; iso_d = 1'b1; rst_n_d = 1'b0; end
            RST_HOLD: begin pwr_en_d = 1'b1; iso_d = 1'b1; rst_n_d = 1'b0; end
            ISO_REL:  begin pwr_en_d = 1'b1; iso_d = 1'b1; rst_n_d = 1'b1; end
            ACTIVE:   begin pwr_en_d = 1'b1; iso_d = 1'b0; rst_n_d = 1'b1; on_d = 1'b1; end
            DRAIN:    begin pwr_en_d = 1'b1; iso_d = 1'b0; rst_n_d = 1'b1; end
            ISO_SET:  begin pwr_en_d = 1'b1; iso_d = 1'b1; rst_n_d = 1'b1; end
            PWR_OFF:  begin pwr_en_d = 1'b0; iso_d = 1'b1; rst_n_d = 1'b0; end
            default:  begin pwr_en_d = 1'b0; iso_d = 1'b1; rst_n_d = 1'b0; end
        endcase
    end

    // State, counter, error and output registers. Reset forces the safe
    // powered-down, isolated outputs immediately, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            alu_pwr_en <= 1'b0;
            iso_en     <= 1'b1;
            alu_rst_n  <= 1'b0;
            domain_on  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            alu_pwr_en <= pwr_en_d;
            iso_en     <= iso_d;
            alu_rst_n  <= rst_n_d;
            domain_on  <= on_d;
        end
    end

    assign pd_state = state_q;
    assign err      = err_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Testbench for alu_pwr_ctrl: table-driven sequence vectors checked through a
// scoreboard queue, plus hand-written reset and timeout sequences.
module tb_alu_pwr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sleep_req, wake_req, alu_busy, pwr_ack;
    logic       alu_pwr_en, iso_en, alu_rst_n, domain_on, err;
    logic [2:0] pd_state;

    alu_pwr_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sleep_req  (sleep_req),
        .wake_req   (wake_req),
        .alu_busy   (alu_busy),
        .pwr_ack    (pwr_ack),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .alu_rst_n  (alu_rst_n),
        .domain_on  (domain_on),
        .pd_state   (pd_state),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       w;
        logic       b;
        logic       a;
        logic [2:0] st;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Expected {alu_pwr_en, iso_en, alu_rst_n} for each state.
    function automatic logic [2:0] stateOutputs(input logic [2:0] st);
        case (st)
            3'd0: return 3'b010;
            3'd1: return 3'b110;
            3'd2: return 3'b110;
            3'd3: return 3'b111;
            3'd4: return 3'b101;
            3'd5: return 3'b101;
            3'd6: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic checkVal(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic addVec(input logic s, input logic w, input logic b,
                          input logic a, input logic [2:0] st);
        vec_t v;
        v.s = s; v.w = w; v.b = b; v.a = a; v.st = st;
        vecs.push_back(v);
    endtask

    // Drive one vector's inputs away from the active edge and queue what the
    // DUT must show after the next rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        sleep_req = v.s;
        wake_req  = v.w;
        alu_busy  = v.b;
        pwr_ack   = v.a;
        e.st  = v.st;
        e.idx = idx;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sbq.pop_front();
        checkVal("pd_state", e.idx, 32'(pd_state), 32'(e.st));
        checkVal("pwr_iso_rst", e.idx, 32'({alu_pwr_en, iso_en, alu_rst_n}),
                 32'(stateOutputs(e.st)));
        checkVal("domain_on", e.idx, 32'(domain_on), 32'(e.st == 3'd4));
        checkVal("err", e.idx, 32'(err), 32'd0);
    endtask

    initial begin
        int n;

        // Power-up, drain with busy, mid-sequence wake, power-down, then a
        // second cycle with both requests held (sleep wins, wake retriggers).
        addVec(0,1,0,0,3'd1); addVec(0,0,0,0,3'd1); addVec(0,0,0,0,3'd1);
        addVec(0,0,0,1,3'd2); addVec(0,0,0,1,3'd2); addVec(0,0,0,1,3'd2);
        addVec(0,0,0,1,3'd2); addVec(0,0,0,1,3'd3); addVec(0,0,0,1,3'd3);
        addVec(0,0,0,1,3'd4); addVec(0,1,0,1,3'd4); addVec(1,1,1,1,3'd5);
        addVec(0,0,1,1,3'd5); addVec(0,0,1,1,3'd5); addVec(0,0,0,1,3'd6);
        addVec(0,1,0,1,3'd6); addVec(0,0,0,1,3'd7); addVec(0,0,0,1,3'd7);
        addVec(0,0,0,0,3'd0); addVec(1,0,0,0,3'd0); addVec(0,1,0,0,3'd1);
        addVec(0,1,0,1,3'd2); addVec(0,1,0,1,3'd2); addVec(0,1,0,1,3'd2);
        addVec(0,1,0,1,3'd2); addVec(0,1,0,1,3'd3); addVec(0,1,0,1,3'd3);
        addVec(0,1,0,1,3'd4); addVec(1,1,0,1,3'd5); addVec(1,1,0,1,3'd6);
        addVec(1,1,0,1,3'd6); addVec(1,1,0,1,3'd7); addVec(1,1,0,0,3'd0);
        addVec(1,1,0,0,3'd1);

        rst_n = 1'b0;
        sleep_req = 1'b0; wake_req = 1'b0; alu_busy = 1'b0; pwr_ack = 1'b0;
        #12;
        checkVal("reset_state", -1, 32'(pd_state), 32'd0);
        checkVal("reset_outputs", -1, 32'({alu_pwr_en, iso_en, alu_rst_n, domain_on, err}),
                 32'(5'b01000));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("post_reset_hold", -1, 32'({pd_state, alu_pwr_en, iso_en, alu_rst_n}),
                 32'({3'd0, 3'b010}));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
            checkOutput();
        end

        // Reset in RST_HOLD must make outputs safe without a clock edge.
        @(negedge clk);
        sleep_req = 1'b0; wake_req = 1'b0; pwr_ack = 1'b1;
        @(posedge clk);
        #1;
        checkVal("mid_rst_pre", -1, 32'(pd_state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst_state", -1, 32'(pd_state), 32'd0);
        checkVal("mid_rst_outputs", -1, 32'({alu_pwr_en, iso_en, alu_rst_n}), 32'(3'b010));
        @(negedge clk);
        pwr_ack = 1'b0;
        rst_n = 1'b1;

        // Power switch never acknowledges.
        @(negedge clk);
        wake_req = 1'b1;
        @(posedge clk);
        #1;
        checkVal("stuck_enter", -1, 32'(pd_state), 32'd1);
`ifdef PWR_TIMEOUT_EN
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (err === 1'b1) begin
                n = k;
                break;
            end
        end
        checkVal("timeout_cycles", -1, 32'(n), 32'd16);
        checkVal("timeout_state", -1, 32'(pd_state), 32'd0);
        checkVal("timeout_outputs", -1, 32'({alu_pwr_en, iso_en, alu_rst_n}), 32'(3'b010));
        repeat (5) @(posedge clk);
        #1;
        checkVal("err_sticky", -1, 32'({err, pd_state}), 32'({1'b1, 3'd0}));
        @(negedge clk);
        wake_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checkVal("err_cleared", -1, 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        n = 0;
        repeat (20) @(posedge clk);
        #1;
        checkVal("no_timeout_state", -1, 32'(pd_state), 32'd1);
        checkVal("no_timeout_err", -1, 32'(err), 32'd0 + 32'(n));
        @(negedge clk);
        wake_req = 1'b0;
        pwr_ack = 1'b1;
        @(posedge clk);
        #1;
        checkVal("late_ack", -1, 32'(pd_state), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
